// File: rtl/uvmt_cv32e40x_debug_chk_pkg.sv
// Shared types and constants for the CV32E40X debug-request handshake checker.
package uvmt_cv32e40x_debug_chk_pkg;

    localparam int LAT_W  = 8;
    localparam int CODE_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DBG  = 2'd2
    } dbg_chk_state_e;

    typedef enum logic [CODE_W-1:0] {
        NONE     = 3'd0,
        SPURIOUS = 3'd1,
        TIMEOUT  = 3'd2,
        REQ_DROP = 3'd3
    } dbg_chk_err_e;

endpackage

// File: rtl/uvmt_cv32e40x_debug_chk_ch.sv
// Single-channel debug-request checker: IDLE/PEND/DBG tracker with latency
// measurement, completed-session counter and sticky first-error code.
module uvmt_cv32e40x_debug_chk_ch
    import uvmt_cv32e40x_debug_chk_pkg::*;
#(
    parameter int CH_IDX   = 0,
    parameter int MAX_LAT  = 16,
    parameter int CNT_W    = 16,
    parameter int REQ_HOLD = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              debug_req_i,
    input  logic              debug_mode_i,
    input  logic              legal_entry_i,
    input  logic              clr_i,
    output logic              err_o,
    output logic [CODE_W-1:0] err_code_o,
    output logic [CNT_W-1:0]  sess_cnt_o,
    output logic [LAT_W-1:0]  max_lat_o
);

    localparam logic [LAT_W-1:0] LAT_LIMIT = LAT_W'(MAX_LAT);
    localparam bit               HOLD      = (REQ_HOLD != 0);

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [LAT_W-1:0] sat_inc_lat(input logic [LAT_W-1:0] v);
        return (&v) ? v : v + LAT_W'(1);
    endfunction

    dbg_chk_state_e   state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d, lat_meas;
    logic             err_q, err_d;
    dbg_chk_err_e     code_q, code_d, code_ev;
    logic [CNT_W-1:0] sess_q, sess_base, sess_d;
    logic [LAT_W-1:0] max_q, max_base, max_d;
    logic             err_ev, sess_ev, meas_ev;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (debug_mode_i)     state_d = DBG;
                else if (debug_req_i) state_d = PEND;
            end
            PEND: begin
                if (debug_mode_i)              state_d = DBG;
                else if (HOLD && !debug_req_i) state_d = IDLE;
            end
            DBG: begin
                // A request still held at exit re-arms immediately.
                if (!debug_mode_i) state_d = (HOLD && debug_req_i) ? PEND : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_ev   = 1'b0;
        code_ev  = NONE;
        sess_ev  = 1'b0;
        meas_ev  = 1'b0;
        lat_meas = '0;
        lat_d    = lat_q;
        unique case (state_q)
            IDLE: begin
                if (debug_mode_i) begin
                    if (!legal_entry_i && debug_req_i) begin
                        meas_ev = 1'b1;
                    end else if (!legal_entry_i) begin
                        err_ev  = 1'b1;
                        code_ev = SPURIOUS;
                    end
                end else if (debug_req_i) begin
                    lat_d = LAT_W'(1);
                end
            end
            PEND: begin
                if (debug_mode_i) begin
                    meas_ev  = 1'b1;
                    lat_meas = lat_q;
                end else if (HOLD && !debug_req_i) begin
                    err_ev  = 1'b1;
                    code_ev = REQ_DROP;
                end else begin
                    if (lat_q == LAT_LIMIT) begin
                        err_ev  = 1'b1;
                        code_ev = TIMEOUT;
                    end
                    lat_d = sat_inc_lat(lat_q);
                end
            end
            DBG: begin
                if (!debug_mode_i) begin
                    sess_ev = 1'b1;
                    if (HOLD && debug_req_i) lat_d = LAT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Clear acts on the old values; this cycle's events land on top of it.
    always_comb begin
        sess_base = clr_i ? '0 : sess_q;
        max_base  = clr_i ? '0 : max_q;
        sess_d    = sess_ev ? sat_inc_cnt(sess_base) : sess_base;
        max_d     = (meas_ev && (lat_meas > max_base)) ? lat_meas : max_base;
        err_d     = err_ev | (err_q & ~clr_i);
        code_d    = clr_i ? NONE : code_q;
        if (err_ev && (clr_i || !err_q)) code_d = code_ev;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lat_q  <= '0;
            err_q  <= 1'b0;
            code_q <= NONE;
            sess_q <= '0;
            max_q  <= '0;
        end else begin
            lat_q  <= lat_d;
            err_q  <= err_d;
            code_q <= code_d;
            sess_q <= sess_d;
            max_q  <= max_d;
        end
    end

    assign err_o      = err_q;
    assign err_code_o = code_q;
    assign sess_cnt_o = sess_q;
    assign max_lat_o  = max_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni && err_ev) begin
            err_coded: assert (code_ev != NONE)
                $info("debug_req_chk: channel %0d flagged code %0d", CH_IDX, code_ev);
        end
    end
`endif

endmodule

// File: rtl/uvmt_cv32e40x_debug_req_chk.sv
// Multi-hart debug-request handshake checker: one independent channel
// checker per hart, outputs packed channel-major.
module uvmt_cv32e40x_debug_req_chk
    import uvmt_cv32e40x_debug_chk_pkg::*;
#(
    parameter int NUM_CH   = 1,
    parameter int MAX_LAT  = 16,
    parameter int CNT_W    = 16,
    parameter int REQ_HOLD = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CH-1:0]       debug_req_i,
    input  logic [NUM_CH-1:0]       debug_mode_i,
    input  logic [NUM_CH-1:0]       legal_entry_i,
    input  logic                    clr_i,
    output logic [NUM_CH-1:0]       err_o,
    output logic [3*NUM_CH-1:0]     err_code_o,
    output logic [CNT_W*NUM_CH-1:0] sess_cnt_o,
    output logic [8*NUM_CH-1:0]     max_lat_o
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        uvmt_cv32e40x_debug_chk_ch #(
            .CH_IDX   (g),
            .MAX_LAT  (MAX_LAT),
            .CNT_W    (CNT_W),
            .REQ_HOLD (REQ_HOLD)
        ) u_ch (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .debug_req_i   (debug_req_i[g]),
            .debug_mode_i  (debug_mode_i[g]),
            .legal_entry_i (legal_entry_i[g]),
            .clr_i         (clr_i),
            .err_o         (err_o[g]),
            .err_code_o    (err_code_o[CODE_W*g +: CODE_W]),
            .sess_cnt_o    (sess_cnt_o[CNT_W*g +: CNT_W]),
            .max_lat_o     (max_lat_o[LAT_W*g +: LAT_W])
        );
    end

endmodule

// File: tb/tb_uvmt_cv32e40x_debug_req_chk.sv
// Scoreboard bench: two checkers (request-hold and pulse mode) share stimulus;
// a behavioural model queues expected outputs, a monitor compares them.
module tb_uvmt_cv32e40x_debug_req_chk;

    localparam int NUM_CH  = 4;
    localparam int MAX_LAT = 16;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;
    logic [NUM_CH-1:0] req, mode, legal;
    logic clr;

    logic [1:0][NUM_CH-1:0]       err_o;
    logic [1:0][3*NUM_CH-1:0]     code_o;
    logic [1:0][CNT_W*NUM_CH-1:0] sess_o;
    logic [1:0][8*NUM_CH-1:0]     maxl_o;

    uvmt_cv32e40x_debug_req_chk #(.NUM_CH(NUM_CH), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W), .REQ_HOLD(1)) u_hold (
        .clk_i(clk), .rst_ni(rst_n), .debug_req_i(req), .debug_mode_i(mode),
        .legal_entry_i(legal), .clr_i(clr), .err_o(err_o[0]), .err_code_o(code_o[0]),
        .sess_cnt_o(sess_o[0]), .max_lat_o(maxl_o[0]));

    uvmt_cv32e40x_debug_req_chk #(.NUM_CH(NUM_CH), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W), .REQ_HOLD(0)) u_pulse (
        .clk_i(clk), .rst_ni(rst_n), .debug_req_i(req), .debug_mode_i(mode),
        .legal_entry_i(legal), .clr_i(clr), .err_o(err_o[1]), .err_code_o(code_o[1]),
        .sess_cnt_o(sess_o[1]), .max_lat_o(maxl_o[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [1:0][NUM_CH-1:0]       err;
        logic [1:0][3*NUM_CH-1:0]     code;
        logic [1:0][CNT_W*NUM_CH-1:0] sess;
        logic [1:0][8*NUM_CH-1:0]     maxl;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Model: pend_lat > 0 means a request is waiting, value is its age.
    int pend_lat [2][NUM_CH];
    bit in_dbg   [2][NUM_CH];
    bit m_err    [2][NUM_CH];
    int m_code   [2][NUM_CH];
    int m_sess   [2][NUM_CH];
    int m_max    [2][NUM_CH];

    task automatic model_update();
        exp_t e;
        bit hold, sess_ev;
        int new_code, meas;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                hold = (d == 0);
                new_code = 0;
                sess_ev = 1'b0;
                meas = -1;
                if (!rst_n) begin
                    pend_lat[d][c] = 0; in_dbg[d][c] = 1'b0; m_err[d][c] = 1'b0;
                    m_code[d][c] = 0; m_sess[d][c] = 0; m_max[d][c] = 0;
                end else begin
                    if (in_dbg[d][c]) begin
                        if (!mode[c]) begin
                            sess_ev = 1'b1;
                            in_dbg[d][c] = 1'b0;
                            if (hold && req[c]) pend_lat[d][c] = 1;
                        end
                    end else if (pend_lat[d][c] > 0) begin
                        if (mode[c]) begin
                            meas = pend_lat[d][c];
                            pend_lat[d][c] = 0;
                            in_dbg[d][c] = 1'b1;
                        end else if (hold && !req[c]) begin
                            new_code = 3;
                            pend_lat[d][c] = 0;
                        end else begin
                            if (pend_lat[d][c] == MAX_LAT) new_code = 2;
                            if (pend_lat[d][c] < 255) pend_lat[d][c]++;
                        end
                    end else if (mode[c]) begin
                        in_dbg[d][c] = 1'b1;
                        if (!legal[c] && !req[c]) new_code = 1;
                        else if (!legal[c]) meas = 0;
                    end else if (req[c]) begin
                        pend_lat[d][c] = 1;
                    end
                    if (clr) begin
                        m_err[d][c] = 1'b0; m_code[d][c] = 0; m_sess[d][c] = 0; m_max[d][c] = 0;
                    end
                    if (new_code != 0) begin
                        if (!m_err[d][c]) m_code[d][c] = new_code;
                        m_err[d][c] = 1'b1;
                    end
                    if (sess_ev && m_sess[d][c] < CNT_MAX) m_sess[d][c]++;
                    if (meas > m_max[d][c]) m_max[d][c] = meas;
                end
                e.err[d][c]                = m_err[d][c];
                e.code[d][3*c +: 3]        = 3'(m_code[d][c]);
                e.sess[d][CNT_W*c +: CNT_W] = CNT_W'(m_sess[d][c]);
                e.maxl[d][8*c +: 8]        = 8'(m_max[d][c]);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic [NUM_CH-1:0] rq, input logic [NUM_CH-1:0] md,
                        input logic [NUM_CH-1:0] lg, input logic cl);
        @(negedge clk);
        rst_n = r; req = rq; mode = md; legal = lg; clr = cl;
        model_update();
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int d = 0; d < 2; d++) begin
                    check($sformatf("err[%0d]", d),  64'(err_o[d]),  64'(e.err[d]));
                    check($sformatf("code[%0d]", d), 64'(code_o[d]), 64'(e.code[d]));
                    check($sformatf("sess[%0d]", d), 64'(sess_o[d]), 64'(e.sess[d]));
                    check($sformatf("maxl[%0d]", d), 64'(maxl_o[d]), 64'(e.maxl[d]));
                end
            end
        end
    end

    initial begin
        logic [NUM_CH-1:0] rq, md, lg;
        logic cl, r;
        rst_n = 1'b0; req = '0; mode = '0; legal = '0; clr = 1'b0;
        step(0, 4'b0000, 4'b0000, 4'b0000, 0);
        step(0, 4'b0000, 4'b0000, 4'b0000, 0);

        // Channels 0/1/3: entry 5 cycles after request; channel 2 times out, enters at 20
        for (int i = 0; i < 5; i++) step(1, 4'b1111, 4'b0000, 4'b0000, 0);
        step(1, 4'b1111, 4'b1011, 4'b0000, 0);
        step(1, 4'b0100, 4'b1011, 4'b0000, 0);
        step(1, 4'b0100, 4'b1011, 4'b0000, 0);
        for (int i = 8; i < 20; i++) step(1, 4'b0100, 4'b0000, 4'b0000, 0);
        step(1, 4'b0100, 4'b0100, 4'b0000, 0);
        step(1, 4'b0000, 4'b0100, 4'b0000, 0);
        step(1, 4'b0000, 4'b0000, 4'b0000, 0);

        // Spurious entry, then a legal entry after clear
        step(1, 4'b0000, 4'b0000, 4'b0000, 1);
        step(1, 4'b0000, 4'b0001, 4'b0000, 0);
        step(1, 4'b0000, 4'b0000, 4'b0000, 0);
        step(1, 4'b0000, 4'b0000, 4'b0000, 1);
        step(1, 4'b0000, 4'b0001, 4'b0001, 0);
        step(1, 4'b0000, 4'b0000, 4'b0000, 0);

        // Request dropped before entry on channel 1
        for (int i = 0; i < 3; i++) step(1, 4'b0010, 4'b0000, 4'b0000, 0);
        for (int i = 0; i < 3; i++) step(1, 4'b0000, 4'b0000, 4'b0000, 0);
        step(1, 4'b0000, 4'b0010, 4'b0010, 0);
        step(1, 4'b0000, 4'b0000, 4'b0000, 0);

        // Re-trigger on exit with request still held (channel 3)
        step(1, 4'b0000, 4'b0000, 4'b0000, 1);
        for (int i = 0; i < 2; i++) step(1, 4'b1000, 4'b0000, 4'b0000, 0);
        for (int i = 0; i < 2; i++) step(1, 4'b1000, 4'b1000, 4'b0000, 0);
        for (int i = 0; i < 4; i++) step(1, 4'b1000, 4'b0000, 4'b0000, 0);
        step(1, 4'b1000, 4'b1000, 4'b0000, 0);
        step(1, 4'b0000, 4'b1000, 4'b0000, 0);
        step(1, 4'b0000, 4'b0000, 4'b0000, 0);

        // Reset mid-pending, then a fresh 3-cycle measurement
        for (int i = 0; i < 7; i++) step(1, 4'b0001, 4'b0000, 4'b0000, 0);
        step(0, 4'b0001, 4'b0000, 4'b0000, 0);
        for (int i = 0; i < 3; i++) step(1, 4'b0001, 4'b0000, 4'b0000, 0);
        step(1, 4'b0001, 4'b0001, 4'b0000, 0);
        step(1, 4'b0000, 4'b0001, 4'b0000, 0);
        step(1, 4'b0000, 4'b0000, 4'b0000, 0);

        // Request and entry in the same cycle, together with clear
        step(1, 4'b0100, 4'b0100, 4'b0000, 1);
        step(1, 4'b0000, 4'b0000, 4'b0000, 0);

        // Session counter saturation
        for (int i = 0; i < 10; i++) begin
            step(1, 4'b0000, 4'b0001, 4'b0001, 0);
            step(1, 4'b0000, 4'b0000, 4'b0000, 0);
        end

        // Latency saturation at 255
        step(1, 4'b0000, 4'b0000, 4'b0000, 1);
        for (int i = 0; i < 300; i++) step(1, 4'b0010, 4'b0000, 4'b0000, 0);
        step(1, 4'b0010, 4'b0010, 4'b0000, 0);
        step(1, 4'b0000, 4'b0000, 4'b0000, 0);

        // Randomised traffic
        rq = '0; md = '0;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(99) < 12) rq[c] = ~rq[c];
                if ($urandom_range(99) < 10) md[c] = ~md[c];
                lg[c] = ($urandom_range(99) < 30);
            end
            cl = ($urandom_range(99) < 3);
            r  = ($urandom_range(199) != 0);
            step(r, rq, md, lg, cl);
        end

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
